mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the dual-issue pipeline, directly downstream of execute. Registers both slots' execute results (EX/MEM), performs slot-0 loads and stores over a req/ack data-memory port, and formats load data. Presents EX/MEM bypass values back to execute and registers the final results into MEM/WB for writeback. Only slot 0 may carry a memory operation.

## Interface
- No parameters.
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- valid0_i, valid1_i  in  1 each  slot carries a live instruction from execute
- alu0_i, alu1_i  in  32 each  execute results; for slot-0 memory ops, alu0_i is the effective address
- store_data_i  in  32  bypassed rs2 of slot 0
- is_load_i, is_store_i  in  1 each  slot-0 memory op
- funct3_i  in  3  slot-0 width/sign code (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW)
- we0_i, we1_i  in  1 each  rd write enable per slot
- rd0_i, rd1_i  in  5 each  rd address per slot
- stall_o  out  1  hold execute and everything upstream
- dmem_req_o  out  1  request valid; held until ack
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wstrb_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  request accepted; for loads, rdata valid in the same cycle
- dmem_rdata_i  in  32  load word
- misaligned_o  out  1  one-cycle pulse, misaligned slot-0 access
- bypass_lsu0_o, bypass_lsu1_o  out  32 each  EX/MEM result per slot
- wm0_o, wm1_o  out  1 each  EX/MEM slot writes rd (bypass valid)
- am0_o, am1_o  out  5 each  EX/MEM rd address
- ww0_o, ww1_o  out  1 each  MEM/WB write enable
- aw0_o, aw1_o  out  5 each  MEM/WB rd
- wb0_o, wb1_o  out  32 each  MEM/WB result

## Operation
- EX/MEM register captures all inputs on each edge where stall_o=0; holds while stall_o=1.
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT on capture of an aligned load/store (valid0_i & (is_load_i|is_store_i)).
  - WAIT: dmem_req_o=1 and address/strb/wdata/we stable from EX/MEM; WAIT -> IDLE on dmem_ack_i.
  - stall_o = (state==WAIT) & !dmem_ack_i.
- Misalignment: LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0. Detected at capture; no request issued, FSM stays IDLE, misaligned_o pulses the following cycle, slot-0 rd write suppressed (ww0_o=0).
- Store lanes: SB wstrb=4'b0001<<addr[1:0], wdata={4{b}}; SH wstrb=addr[1]?4'b1100:4'b0011, wdata={2{h}}; SW 4'b1111.
- Load format: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough. funct3 3'b011/3'b110/3'b111 treated as LW.
- MEM/WB capture: when not stalled, slot-0 result = formatted load data for loads, alu0 for everything else; ww0 = valid0 & we0 & !store & !misaligned; slot 1 = alu1, ww1 = valid1 & we1. When stalled, ww0_o/ww1_o cleared to 0 (bubble).
- wm0_o = valid0 & we0 & !is_load (EX/MEM); wm1_o = valid1 & we1. Writes to x0 are passed through; consumers ignore x0.
- Memory flags on slot 1 are not supported; slot-1 side ignores them.

## Timing
- Reset (async, immediate): state=IDLE, all valid/write/req/misaligned/strb outputs 0, all data/address outputs 0.
- Non-memory instruction: 1 cycle in stage; visible on bypass outputs the cycle after execute, on wb outputs one cycle later.
- Memory op captured at edge N: dmem_req_o high from cycle N+1; ack in cycle N+k releases stall_o in that same cycle; result on wb outputs after edge N+k. Minimum 2 cycles (ack in N+1, stall_o never asserted).
- Ack while IDLE is ignored.
- Reset during WAIT drops dmem_req_o immediately; transaction abandoned.

## Configuration
- LSU_LOAD_BYPASS_EN defined: during the ack cycle of a load, wm0_o=we0 and bypass_lsu0_o=formatted load data, so a dependent instruction held in execute can consume it without an extra cycle. Undefined: wm0_o=0 for loads at all times; load-use resolved only through writeback.

## Test plan
- ADD in slot 0 (alu0=0x10, rd=5) and slot 1 (alu1=0x20, rd=6), no memory -> next cycle bypass/wm/am reflect both; next edge wb0=0x10/aw0=5/ww0=1, wb1=0x20/aw1=6/ww1=1.
- LB addr 0x1003, ack after 3 wait cycles, rdata 0x80FFFFFF -> dmem_addr 0x1000, stall_o high 3 cycles, wb0=0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr 0x2002 data 0x1234ABCD, immediate ack -> wstrb 4'b1100, wdata 0xABCDABCD, we=1, stall_o never high, ww0=0.
- LW addr 0x3001 -> no dmem_req, misaligned_o pulse 1 cycle, ww0=0.
- Reset asserted in WAIT -> dmem_req_o and stall_o 0 same cycle; after release next aligned SW issues normally.
- LSU_LOAD_BYPASS_EN on/off: LW rd=7, ack rdata 0xDEADBEEF -> ack cycle wm0=1/am0=7/bypass_lsu0=0xDEADBEEF when defined; wm0=0 when undefined.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the dual-issue pipeline.
//
// The EX/MEM register holds both slots' execute results. Slot 0 can carry a
// load or store, which goes out on a req/ack data-memory port; load data is
// formatted to width and sign. Results are then registered into MEM/WB.
//
// Ports
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   valid*/alu*/we*/rd*      per-slot results from execute
//   store_data_i             slot-0 store data (bypassed rs2)
//   is_load_i, is_store_i    slot-0 memory operation
//   funct3_i                 slot-0 width/sign code
//   stall_o                  holds execute and everything upstream
//   dmem_*                   data-memory request/ack port (word-aligned)
//   misaligned_o             one-cycle pulse for a misaligned slot-0 access
//   bypass_lsu*/wm*/am*      EX/MEM bypass value, write flag and rd
//   ww*/aw*/wb*              MEM/WB write enable, rd and result
//
// Optional feature macro: LSU_LOAD_BYPASS_EN
//   When defined, load data is forwarded on bypass_lsu0_o during the ack
//   cycle. When undefined, loads never drive the EX/MEM bypass.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no memory transaction outstanding; EX/MEM captures freely
// WAIT   | slot-0 request on dmem, pipeline held until dmem_ack_i

module mem_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid0_i,
  input  logic        valid1_i,
  input  logic [31:0] alu0_i,
  input  logic [31:0] alu1_i,
  input  logic [31:0] store_data_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [4:0]  rd0_i,
  input  logic [4:0]  rd1_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_wstrb_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        misaligned_o,
  output logic [31:0] bypass_lsu0_o,
  output logic [31:0] bypass_lsu1_o,
  output logic        wm0_o,
  output logic        wm1_o,
  output logic [4:0]  am0_o,
  output logic [4:0]  am1_o,
  output logic        ww0_o,
  output logic        ww1_o,
  output logic [4:0]  aw0_o,
  output logic [4:0]  aw1_o,
  output logic [31:0] wb0_o,
  output logic [31:0] wb1_o
);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;

  // EX/MEM register
  logic        em_v0, em_v1, em_ld, em_st, em_we0, em_we1, em_mis;
  logic [31:0] em_a0, em_a1, em_sd;
  logic [2:0]  em_f3;
  logic [4:0]  em_rd0, em_rd1;

  logic        mem_in, mis_in, go_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic [3:0]  strb;

  // funct3[1:0] alone decides access width: 00 byte, 01 half, else word.
  // That folds 3'b011/3'b110/3'b111 into the word case.
  always_comb begin
    mem_in = valid0_i & (is_load_i | is_store_i);
    mis_in = 1'b0;
    case (funct3_i[1:0])
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = alu0_i[0];
      default: mis_in = |alu0_i[1:0];
    endcase
    mis_in = mis_in & mem_in;
    go_in  = mem_in & ~mis_in;
  end

  assign stall_o = (state_q == S_WAIT) & ~dmem_ack_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      em_v0  <= 1'b0;
      em_v1  <= 1'b0;
      em_ld  <= 1'b0;
      em_st  <= 1'b0;
      em_we0 <= 1'b0;
      em_we1 <= 1'b0;
      em_mis <= 1'b0;
      em_a0  <= '0;
      em_a1  <= '0;
      em_sd  <= '0;
      em_f3  <= '0;
      em_rd0 <= '0;
      em_rd1 <= '0;
    end else if (!stall_o) begin
      em_v0  <= valid0_i;
      em_v1  <= valid1_i;
      em_ld  <= is_load_i;
      em_st  <= is_store_i;
      em_we0 <= we0_i;
      em_we1 <= we1_i;
      em_mis <= mis_in;
      em_a0  <= alu0_i;
      em_a1  <= alu1_i;
      em_sd  <= store_data_i;
      em_f3  <= funct3_i;
      em_rd0 <= rd0_i;
      em_rd1 <= rd1_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // The ack cycle also captures the next instruction, so a back-to-back
  // memory op goes straight from WAIT to WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_in) state_d = S_WAIT;
      S_WAIT:  if (dmem_ack_i) state_d = go_in ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load formatting
  always_comb begin
    byte_sel = 8'h00;
    case (em_a0[1:0])
      2'b00: byte_sel = dmem_rdata_i[7:0];
      2'b01: byte_sel = dmem_rdata_i[15:8];
      2'b10: byte_sel = dmem_rdata_i[23:16];
      2'b11: byte_sel = dmem_rdata_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = em_a0[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (em_f3[1:0])
      2'b00:   load_fmt = {{24{byte_sel[7] & ~em_f3[2]}}, byte_sel};
      2'b01:   load_fmt = {{16{half_sel[15] & ~em_f3[2]}}, half_sel};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  // Store lanes
  always_comb begin
    case (em_f3[1:0])
      2'b00: begin
        strb         = 4'b0001 << em_a0[1:0];
        dmem_wdata_o = {4{em_sd[7:0]}};
      end
      2'b01: begin
        strb         = em_a0[1] ? 4'b1100 : 4'b0011;
        dmem_wdata_o = {2{em_sd[15:0]}};
      end
      default: begin
        strb         = 4'b1111;
        dmem_wdata_o = em_sd;
      end
    endcase
  end

  assign dmem_req_o   = (state_q == S_WAIT);
  assign dmem_we_o    = em_st;
  assign dmem_addr_o  = {em_a0[31:2], 2'b00};
  assign dmem_wstrb_o = (dmem_req_o & em_st) ? strb : 4'b0000;
  assign misaligned_o = em_mis;

  assign bypass_lsu1_o = em_a1;
  assign wm1_o         = em_v1 & em_we1;
  assign am0_o         = em_rd0;
  assign am1_o         = em_rd1;

`ifdef LSU_LOAD_BYPASS_EN
  logic load_fwd;
  assign load_fwd      = (state_q == S_WAIT) & dmem_ack_i & em_ld;
  assign wm0_o         = em_v0 & em_we0 & (~em_ld | load_fwd);
  assign bypass_lsu0_o = load_fwd ? load_fmt : em_a0;
`else
  assign wm0_o         = em_v0 & em_we0 & ~em_ld;
  assign bypass_lsu0_o = em_a0;
`endif

  // MEM/WB register; a stalled cycle inserts a bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ww0_o <= 1'b0;
      ww1_o <= 1'b0;
      aw0_o <= '0;
      aw1_o <= '0;
      wb0_o <= '0;
      wb1_o <= '0;
    end else if (stall_o) begin
      ww0_o <= 1'b0;
      ww1_o <= 1'b0;
    end else begin
      ww0_o <= em_v0 & em_we0 & ~em_st & ~em_mis;
      ww1_o <= em_v1 & em_we1;
      aw0_o <= em_rd0;
      aw1_o <= em_rd1;
      wb0_o <= (em_ld & ~em_mis) ? load_fmt : em_a0;
      wb1_o <= em_a1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk, rst_n;
  logic        valid0, valid1, is_load, is_store, we0, we1;
  logic [31:0] alu0, alu1, store_data;
  logic [2:0]  funct3;
  logic [4:0]  rd0, rd1;
  logic        stall, dmem_req, dmem_we, dmem_ack, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] bp0, bp1, wb0, wb1;
  logic        wm0, wm1, ww0, ww1;
  logic [4:0]  am0, am1, aw0, aw1;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid0_i(valid0), .valid1_i(valid1),
    .alu0_i(alu0), .alu1_i(alu1), .store_data_i(store_data),
    .is_load_i(is_load), .is_store_i(is_store), .funct3_i(funct3),
    .we0_i(we0), .we1_i(we1), .rd0_i(rd0), .rd1_i(rd1),
    .stall_o(stall),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wstrb_o(dmem_wstrb), .dmem_wdata_o(dmem_wdata),
    .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
    .misaligned_o(misaligned),
    .bypass_lsu0_o(bp0), .bypass_lsu1_o(bp1),
    .wm0_o(wm0), .wm1_o(wm1), .am0_o(am0), .am1_o(am1),
    .ww0_o(ww0), .ww1_o(ww1), .aw0_o(aw0), .aw1_o(aw1),
    .wb0_o(wb0), .wb1_o(wb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    valid0 = 0; valid1 = 0; is_load = 0; is_store = 0; we0 = 0; we1 = 0;
    alu0 = 0; alu1 = 0; store_data = 0; funct3 = 0; rd0 = 0; rd1 = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #3;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
    checks++; if (dmem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %h expected 0", dmem_wstrb); end
    checks++; if ({ww0, ww1, wm0, wm1, misaligned} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {ww0, ww1, wm0, wm1, misaligned}); end
    checks++; if ({wb0, wb1, bp0, dmem_addr} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {wb0, wb1, bp0, dmem_addr}); end
    step();
    rst_n = 1;
  endtask

  task automatic test_alu_pair();
    valid0 = 1; alu0 = 32'h10; we0 = 1; rd0 = 5;
    valid1 = 1; alu1 = 32'h20; we1 = 1; rd1 = 6;
    step();
    clear_inputs();
    checks++; if (bp0 !== 32'h10 || wm0 !== 1'b1 || am0 !== 5'd5) begin errors++; $display("FAIL alu_bypass0: got %h/%b/%0d expected 10/1/5", bp0, wm0, am0); end
    checks++; if (bp1 !== 32'h20 || wm1 !== 1'b1 || am1 !== 5'd6) begin errors++; $display("FAIL alu_bypass1: got %h/%b/%0d expected 20/1/6", bp1, wm1, am1); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b expected 0", dmem_req); end
    step();
    checks++; if (wb0 !== 32'h10 || aw0 !== 5'd5 || ww0 !== 1'b1) begin errors++; $display("FAIL alu_wb0: got %h/%0d/%b expected 10/5/1", wb0, aw0, ww0); end
    checks++; if (wb1 !== 32'h20 || aw1 !== 5'd6 || ww1 !== 1'b1) begin errors++; $display("FAIL alu_wb1: got %h/%0d/%b expected 20/6/1", wb1, aw1, ww1); end
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input int waits,
                           input logic [31:0] expd, input logic [4:0] rd);
    valid0 = 1; is_load = 1; funct3 = f3; alu0 = addr; we0 = 1; rd0 = rd;
    step();
    clear_inputs();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("FAIL load_req: got req=%b we=%b expected 1/0", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL load_addr: got %h expected %h", dmem_addr, {addr[31:2], 2'b00}); end
    checks++; if (wm0 !== 1'b0) begin errors++; $display("FAIL load_wm0_wait: got %b expected 0", wm0); end
    for (int i = 0; i < waits; i++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_wait%0d: got %b expected 1", i, stall); end
      step();
    end
    dmem_ack = 1; dmem_rdata = rdata;
    #1;
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b1) begin errors++; $display("FAIL load_ack_cycle: got stall=%b req=%b expected 0/1", stall, dmem_req); end
`ifdef LSU_LOAD_BYPASS_EN
    checks++; if (wm0 !== 1'b1 || am0 !== rd || bp0 !== expd) begin errors++; $display("FAIL load_bypass: got %b/%0d/%h expected 1/%0d/%h", wm0, am0, bp0, rd, expd); end
`else
    checks++; if (wm0 !== 1'b0 || am0 !== rd) begin errors++; $display("FAIL load_bypass: got wm0=%b am0=%0d expected 0/%0d", wm0, am0, rd); end
`endif
    step();
    clear_inputs();
    checks++; if (wb0 !== expd || ww0 !== 1'b1 || aw0 !== rd) begin errors++; $display("FAIL load_wb: got %h/%b/%0d expected %h/1/%0d", wb0, ww0, aw0, expd, rd); end
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL load_done: got req=%b stall=%b expected 0/0", dmem_req, stall); end
  endtask

  task automatic test_store_half();
    valid0 = 1; is_store = 1; funct3 = 3'b001; alu0 = 32'h2002;
    store_data = 32'h1234ABCD; we0 = 1; rd0 = 4;
    step();
    clear_inputs();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL sh_req: got req=%b we=%b expected 1/1", dmem_req, dmem_we); end
    checks++; if (dmem_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b expected 1100", dmem_wstrb); end
    checks++; if (dmem_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", dmem_wdata); end
    checks++; if (dmem_addr !== 32'h2000) begin errors++; $display("FAIL sh_addr: got %h expected 2000", dmem_addr); end
    dmem_ack = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sh_stall: got %b expected 0", stall); end
    step();
    clear_inputs();
    checks++; if (ww0 !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL sh_wb: got ww0=%b req=%b expected 0/0", ww0, dmem_req); end
  endtask

  task automatic test_store_byte();
    valid0 = 1; is_store = 1; funct3 = 3'b000; alu0 = 32'h0000_0101;
    store_data = 32'hFFFF_FF5A;
    step();
    clear_inputs();
    checks++; if (dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_lanes: got %b/%h expected 0010/5a5a5a5a", dmem_wstrb, dmem_wdata); end
    dmem_ack = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_misaligned();
    valid0 = 1; is_load = 1; funct3 = 3'b010; alu0 = 32'h3001; we0 = 1; rd0 = 9;
    step();
    clear_inputs();
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", misaligned); end
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mis_no_req: got req=%b stall=%b expected 0/0", dmem_req, stall); end
    step();
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b expected 0", misaligned); end
    checks++; if (ww0 !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL mis_wb: got ww0=%b req=%b expected 0/0", ww0, dmem_req); end
  endtask

  task automatic test_ack_idle();
    dmem_ack = 1;
    #1;
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL idle_ack: got stall=%b req=%b expected 0/0", stall, dmem_req); end
    step();
    dmem_ack = 0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_after: got %b expected 0", dmem_req); end
  endtask

  task automatic test_reset_in_wait();
    valid0 = 1; is_load = 1; funct3 = 3'b010; alu0 = 32'h4000; we0 = 1; rd0 = 2;
    step();
    clear_inputs();
    checks++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL rw_wait: got req=%b stall=%b expected 1/1", dmem_req, stall); end
    rst_n = 0;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rw_async: got req=%b stall=%b expected 0/0", dmem_req, stall); end
    #2;
    rst_n = 1;
    step();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rw_abandon: got %b expected 0", dmem_req); end
    valid0 = 1; is_store = 1; funct3 = 3'b010; alu0 = 32'h5004; store_data = 32'hCAFEF00D;
    step();
    clear_inputs();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wstrb !== 4'b1111) begin errors++; $display("FAIL rw_sw_req: got req=%b we=%b strb=%b expected 1/1/1111", dmem_req, dmem_we, dmem_wstrb); end
    checks++; if (dmem_addr !== 32'h5004 || dmem_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_sw_data: got %h/%h expected 5004/cafef00d", dmem_addr, dmem_wdata); end
    step();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_sw_stall: got %b expected 1", stall); end
    dmem_ack = 1;
    step();
    clear_inputs();
    checks++; if (dmem_req !== 1'b0 || ww0 !== 1'b0) begin errors++; $display("FAIL rw_sw_done: got req=%b ww0=%b expected 0/0", dmem_req, ww0); end
  endtask

  initial begin
    test_reset();
    step();
    test_alu_pair();
    test_load(32'h1003, 3'b000, 32'h80FFFFFF, 3, 32'hFFFFFF80, 5'd3);
    test_load(32'h1003, 3'b100, 32'h80FFFFFF, 3, 32'h00000080, 5'd3);
    test_load(32'h1002, 3'b001, 32'h80FF1234, 1, 32'hFFFF80FF, 5'd8);
    test_load(32'h1002, 3'b101, 32'h80FF1234, 0, 32'h000080FF, 5'd8);
    test_store_half();
    test_store_byte();
    test_misaligned();
    test_ack_idle();
    test_reset_in_wait();
    test_load(32'h6000, 3'b010, 32'hDEADBEEF, 0, 32'hDEADBEEF, 5'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
